// File: rtl/sram_fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl_pkg
//   Default geometry for the SRAM-backed valid/ready FIFO. Every width inside
//   the design is derived locally from the WIDTH/DEPTH parameters. This package
//   only supplies the default values those parameters take.
// -----------------------------------------------------------------------------
package sram_fifo_ctrl_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 16;

endpackage : sram_fifo_ctrl_pkg

// File: rtl/sram_1w1r.sv
// -----------------------------------------------------------------------------
// sram_1w1r
//   One-write / one-read synchronous SRAM model. The read has 1 cycle of
//   latency through a registered output. When a read and a write hit the same
//   address in one cycle, the read returns the old contents.
// Ports
//   i_clk     clock
//   i_w_e     write enable
//   i_w_addr  write address
//   i_w_data  write data
//   i_r_e     read enable; o_r_data updates on the next edge
//   i_r_addr  read address
//   o_r_data  registered read data (held when i_r_e=0)
// -----------------------------------------------------------------------------
module sram_1w1r #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_w_e,
  input  logic [$clog2(DEPTH)-1:0] i_w_addr,
  input  logic [WIDTH-1:0]         i_w_data,
  input  logic                     i_r_e,
  input  logic [$clog2(DEPTH)-1:0] i_r_addr,
  output logic [WIDTH-1:0]         o_r_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // NOTE: the array and its read register carry no reset. This lets the tool
  // map them onto a real SRAM macro. Nothing downstream consumes r_rdata
  // unless a read was issued first.
  always_ff @(posedge i_clk) begin
    if (i_w_e) r_mem[i_w_addr] <= i_w_data;
    if (i_r_e) r_rdata <= r_mem[i_r_addr];
  end

  assign o_r_data = r_rdata;

endmodule : sram_1w1r

// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
//   Valid/ready FIFO built on one sram_1w1r. A 2-entry output buffer hides the
//   SRAM's registered read latency, so the FIFO sustains 1 enqueue and
//   1 dequeue per cycle. Total capacity is DEPTH+2 entries.
// Ports
//   i_clk, i_rst_n            clock; asynchronous active-low reset
//   i_flush                   synchronous discard of all contents
//   i_enq_valid/o_enq_ready   enqueue handshake, payload i_enq_data
//   o_deq_valid/i_deq_ready   dequeue handshake, payload o_deq_data
//   o_count                   entries held (SRAM + in-flight read + buffer)
//   o_empty / o_full          o_count==0 / o_count==DEPTH+2
// -----------------------------------------------------------------------------
module sram_fifo_ctrl
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_enq_valid,
  output logic                       o_enq_ready,
  input  logic [WIDTH-1:0]           i_enq_data,
  output logic                       o_deq_valid,
  input  logic                       i_deq_ready,
  output logic [WIDTH-1:0]           o_deq_data,
  output logic [$clog2(DEPTH+3)-1:0] o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+3);
  localparam logic [AW:0]   SRAM_FULL  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TOTAL_FULL = CW'(DEPTH + 2);

  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_sram_cnt;     // written, not yet read-issued
  logic             r_rd_pending;   // SRAM read data lands this cycle
  logic [1:0]       r_out_cnt;      // output buffer occupancy, 0..2
  logic [WIDTH-1:0] r_out_data0;    // head
  logic [WIDTH-1:0] r_out_data1;

  logic             w_enq_fire, w_deq_fire, w_issue, w_push;
  logic [2:0]       w_occ;
  logic [WIDTH-1:0] w_r_data;

  // Flush beats same-cycle handshakes, so both fires are masked by it.
  assign w_enq_fire = i_enq_valid & o_enq_ready & ~i_flush;
  assign w_deq_fire = o_deq_valid & i_deq_ready & ~i_flush;

  // A read issued now lands next cycle, so the buffer must have room for it
  // once this cycle's pop has been counted. Only committed SRAM entries are
  // read, so a read never targets this cycle's write address.
  assign w_occ   = 3'(r_out_cnt) + 3'(r_rd_pending);
  assign w_issue = (r_sram_cnt != '0) & ~i_flush &
                   ((w_occ < 3'd2) | (w_deq_fire & (w_occ == 3'd2)));
  assign w_push  = r_rd_pending & ~i_flush;

  sram_1w1r #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk    (i_clk),
    .i_w_e    (w_enq_fire),
    .i_w_addr (r_wr_ptr),
    .i_w_data (i_enq_data),
    .i_r_e    (w_issue),
    .i_r_addr (r_rd_ptr),
    .o_r_data (w_r_data)
  );

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values and evaluation order inside the block is irrelevant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_sram_cnt   <= '0;
      r_rd_pending <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_sram_cnt   <= '0;
      r_rd_pending <= 1'b0;
    end else begin
      if (w_enq_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue)    r_rd_ptr <= r_rd_ptr + 1'b1;
      r_rd_pending <= w_issue;
      if (w_enq_fire && !w_issue)      r_sram_cnt <= r_sram_cnt + 1'b1;
      else if (!w_enq_fire && w_issue) r_sram_cnt <= r_sram_cnt - 1'b1;
    end
  end

  // Output buffer: shift-style 2-entry FIFO with r_out_data0 as head.
  // The issue rule rules out a push into a full buffer and a pop from an
  // empty one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_cnt   <= '0;
      r_out_data0 <= '0;
      r_out_data1 <= '0;
    end else if (i_flush) begin
      r_out_cnt <= '0;
    end else begin
      unique case ({w_push, w_deq_fire})
        2'b10: begin
          if (r_out_cnt == 2'd0) r_out_data0 <= w_r_data;
          else                   r_out_data1 <= w_r_data;
          r_out_cnt <= r_out_cnt + 1'b1;
        end
        2'b01: begin
          r_out_data0 <= r_out_data1;
          r_out_cnt   <= r_out_cnt - 1'b1;
        end
        2'b11: begin
          if (r_out_cnt == 2'd1) begin
            r_out_data0 <= w_r_data;
          end else begin
            r_out_data0 <= r_out_data1;
            r_out_data1 <= w_r_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_enq_ready = (r_sram_cnt < SRAM_FULL);
  assign o_deq_valid = (r_out_cnt != 2'd0);
  assign o_deq_data  = r_out_data0;
  assign o_count     = CW'(r_sram_cnt) + CW'(r_rd_pending) + CW'(r_out_cnt);
  assign o_empty     = (o_count == '0);
  assign o_full      = (o_count == TOTAL_FULL);

endmodule : sram_fifo_ctrl
